// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment lab blocks.
//   - Active-low segment patterns, bit order gfedcba.
//   - FSM state type for bin2dec_seq.
//   - Double-dabble nibble adjust helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Letters of the existing "Err" display.
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_R = 7'b0101111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } b2d_state_e;

  // A BCD nibble of 5 or more would overflow past 9 after the next
  // doubling, so it is pre-corrected by +3 before the shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational BCD digit to seven-segment decoder.
//   digit : 4-bit BCD value
//   blank : 1 forces the display dark
//   seg   : active-low segments, gfedcba
// Values above 9 are not legal BCD and decode to blank.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bin2dec_seq.sv
// bin2dec_seq: sequential binary to 3-digit BCD converter (double dabble,
// one bit per clock) driving three seven-segment displays.
//
// Ports:
//   CLOCK_50  : clock, all state changes on the rising edge
//   RST       : synchronous reset, active-high
//   SW        : WIDTH-bit unsigned value, captured on an accepted START edge
//   START     : level input; a rising edge (START=1, previous=0) requests a
//               conversion when idle
//   BUSY      : high from the cycle after the edge until the result cycle
//   DONE      : one-cycle pulse in the cycle new results first appear
//   BCD       : {hundreds, tens, ones}, registered
//   LEDG      : BCD[7:0]
//   HEX2..0   : active-low segments (gfedcba), hundreds/tens/ones
//   dbg_state : current FSM state
//
// Handshake: START is a request-by-edge; it is accepted only in IDLE and
// never queued. An accepted edge gives exactly one DONE pulse WIDTH+1
// cycles later, unless RST intervenes, which discards the conversion.
//
// WIDTH is legal from 4 to 9 so the result always fits three digits.
module bin2dec_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic [11:0]      BCD,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX0,
  output logic [1:0]       dbg_state
);

  localparam int SR_W  = WIDTH + 12;
  localparam int CNT_W = $clog2(WIDTH);

  b2d_state_e       state, state_next;
  logic             start_q;
  logic [SR_W-1:0]  sr, sr_next, sr_shift;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             busy, busy_next;
  logic             done, done_next;
  logic [11:0]      bcd_r, bcd_next;
  logic [6:0]       hex2_r, hex1_r, hex0_r;
  logic [6:0]       hex2_next, hex1_next, hex0_next;
  logic [11:0]      bcd_adj, res_bcd;
  logic [6:0]       dec2, dec1, dec0;
  logic             blank2, blank1;
  logic             start_edge;

  assign start_edge = START & ~start_q;

  // One double-dabble step: all three nibbles corrected in parallel on the
  // pre-shift value, then the whole register moves left by one bit.
  always_comb begin
    bcd_adj[11:8] = dd_adjust(sr[SR_W-1 -: 4]);
    bcd_adj[7:4]  = dd_adjust(sr[SR_W-5 -: 4]);
    bcd_adj[3:0]  = dd_adjust(sr[SR_W-9 -: 4]);
    sr_shift      = {bcd_adj, sr[WIDTH-1:0]} << 1;
  end

  // After the final step, the BCD part of the shifted register is the result.
  assign res_bcd = sr_shift[SR_W-1:WIDTH];

  assign blank2 = BLANK_LEAD && (res_bcd[11:8] == 4'd0);
  assign blank1 = BLANK_LEAD && (res_bcd[11:8] == 4'd0) && (res_bcd[7:4] == 4'd0);

  seg7_dec u_dec2 (.digit(res_bcd[11:8]), .blank(blank2), .seg(dec2));
  seg7_dec u_dec1 (.digit(res_bcd[7:4]),  .blank(blank1), .seg(dec1));
  seg7_dec u_dec0 (.digit(res_bcd[3:0]),  .blank(1'b0),   .seg(dec0));

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    busy_next  = busy;
    done_next  = 1'b0;
    bcd_next   = bcd_r;
    hex2_next  = hex2_r;
    hex1_next  = hex1_r;
    hex0_next  = hex0_r;

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          sr_next    = {12'b0, SW};
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sr_next  = sr_shift;
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          // The last shift lands together with the output registers so the
          // result and DONE are both visible throughout the FINISH cycle.
          state_next = ST_FINISH;
          done_next  = 1'b1;
          bcd_next   = res_bcd;
          hex2_next  = dec2;
          hex1_next  = dec1;
          hex0_next  = dec0;
        end
      end

      ST_FINISH: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      sr      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_r   <= '0;
      hex2_r  <= SEG_BLANK;
      hex1_r  <= SEG_BLANK;
      hex0_r  <= SEG_BLANK;
    end else begin
      state   <= state_next;
      start_q <= START;
      sr      <= sr_next;
      cnt     <= cnt_next;
      busy    <= busy_next;
      done    <= done_next;
      bcd_r   <= bcd_next;
      hex2_r  <= hex2_next;
      hex1_r  <= hex1_next;
      hex0_r  <= hex0_next;
    end
  end

  assign BUSY      = busy;
  assign DONE      = done;
  assign BCD       = bcd_r;
  assign LEDG      = bcd_r[7:0];
  assign HEX2      = hex2_r;
  assign HEX1      = hex1_r;
  assign HEX0      = hex0_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_bin2dec_seq.sv
// Testbench for bin2dec_seq: two instances (leading-zero blanking on and
// off) share one stimulus stream; results are compared with a decimal
// reference computed by division and a digit pattern table.
module tb_bin2dec_seq;
  import seg7_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic       start;
  logic [7:0] sw;

  logic        busy, done, busy_nb, done_nb;
  logic [11:0] bcd, bcd_nb;
  logic [7:0]  ledg, ledg_nb;
  logic [6:0]  hex2, hex1, hex0, hex2_nb, hex1_nb, hex0_nb;
  logic [1:0]  dbg_state, dbg_state_nb;

  bin2dec_seq #(.WIDTH(8), .BLANK_LEAD(1'b1)) dut (
    .CLOCK_50(clk), .RST(rst), .SW(sw), .START(start),
    .BUSY(busy), .DONE(done), .BCD(bcd), .LEDG(ledg),
    .HEX2(hex2), .HEX1(hex1), .HEX0(hex0), .dbg_state(dbg_state)
  );

  bin2dec_seq #(.WIDTH(8), .BLANK_LEAD(1'b0)) dut_nb (
    .CLOCK_50(clk), .RST(rst), .SW(sw), .START(start),
    .BUSY(busy_nb), .DONE(done_nb), .BCD(bcd_nb), .LEDG(ledg_nb),
    .HEX2(hex2_nb), .HEX1(hex1_nb), .HEX0(hex0_nb), .dbg_state(dbg_state_nb)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int last_val = -1;  // -1: outputs should still hold reset values

  logic [6:0] seg_tbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    if (v < 0) return 12'h000;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // idx 2/1/0 = hundreds/tens/ones display
  function automatic logic [6:0] ref_hex(input int v, input bit blank_lead, input int idx);
    int h, t, o;
    if (v < 0) return 7'b1111111;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (idx)
      2:       return (blank_lead && h == 0) ? 7'b1111111 : seg_tbl[h];
      1:       return (blank_lead && v < 10) ? 7'b1111111 : seg_tbl[t];
      default: return seg_tbl[o];
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    logic [11:0] eb;
    eb = ref_bcd(last_val);
    check({tag, ".bcd"},     bcd,     eb);
    check({tag, ".ledg"},    ledg,    eb[7:0]);
    check({tag, ".hex2"},    hex2,    ref_hex(last_val, 1'b1, 2));
    check({tag, ".hex1"},    hex1,    ref_hex(last_val, 1'b1, 1));
    check({tag, ".hex0"},    hex0,    ref_hex(last_val, 1'b1, 0));
    check({tag, ".nb_hex2"}, hex2_nb, ref_hex(last_val, 1'b0, 2));
    check({tag, ".nb_hex1"}, hex1_nb, ref_hex(last_val, 1'b0, 1));
    check({tag, ".nb_hex0"}, hex0_nb, ref_hex(last_val, 1'b0, 0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".busy"},  busy,      1'b0);
    check({tag, ".done"},  done,      1'b0);
    check({tag, ".state"}, dbg_state, ST_IDLE);
    check_outputs(tag);
  endtask

  // ---------------- driver ----------------
  // One conversion request. k counts cycles after the edge-sample edge
  // (observed 1 time unit after each rising edge). Optional disturbances:
  // SW change at sw_k, a START pulse at pulse_k, RST at rst_k, START held.
  task automatic conv(input string tag, input int val, input int sw_k, input int sw_val,
                      input int pulse_k, input int rst_k, input bit hold);
    int done_k = 0, done_cnt = 0, busy_cnt = 0, early_chg = 0;
    logic [11:0] prev_bcd;
    prev_bcd = ref_bcd(last_val);
    start = 1'b0;
    @(posedge clk); #1;
    sw    = 8'(val);
    start = 1'b1;
    @(posedge clk); #1;  // edge sampled here
    for (int k = 1; k <= 14; k++) begin
      if (done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      if (busy) busy_cnt++;
      if (k < 9 && rst_k == 0 && bcd !== prev_bcd) early_chg++;
      if (rst_k != 0 && k == rst_k + 1) begin
        last_val = -1;
        check_reset_state({tag, ".rst"});
      end
      if (!hold) start = (k == pulse_k);
      if (k == sw_k) sw = 8'(sw_val);
      rst = (k == rst_k);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (rst_k == 0) begin
      last_val = val;
      check({tag, ".done_cycle"}, done_k,    9);
      check({tag, ".done_count"}, done_cnt,  1);
      check({tag, ".busy_cycles"}, busy_cnt, 9);
      check({tag, ".no_early"},   early_chg, 0);
      check_outputs(tag);
    end else begin
      check({tag, ".done_count"}, done_cnt, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v, sk, sv, pk;
    rst   = 1'b1;
    start = 1'b0;
    sw    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    conv("zero",  0,   0, 0,   0, 0, 1'b0);
    conv("max",   255, 0, 0,   0, 0, 1'b0);
    conv("hund",  100, 0, 0,   0, 0, 1'b0);
    conv("nine",  9,   0, 0,   0, 0, 1'b0);
    conv("busy",  37,  3, 200, 4, 0, 1'b0);
    conv("c123",  123, 0, 0,   0, 0, 1'b0);
    conv("abort", 45,  0, 0,   0, 5, 1'b0);
    conv("c45",   45,  0, 0,   0, 0, 1'b0);
    conv("hold",  77,  0, 0,   0, 0, 1'b1);
    conv("ten",   10,  0, 0,   0, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      v  = $urandom_range(0, 255);
      sk = $urandom_range(1, 8);
      sv = $urandom_range(0, 255);
      pk = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 9) : 0;
      conv("rand", v, sk, sv, pk, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
